// File: rtl/if_fetch_if.sv
`default_nettype none
// Fetch-stage bus: instruction-memory request/ack plus the decode-side valid/stall/flush handshake.
interface if_fetch_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [31:0] inst_o;

  modport master (
    output imem_req_o, imem_addr_o, valid_o, pc_o, inst_o,
    input  imem_ack_i, imem_data_i, stall_i, flush_i, flush_pc_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, valid_o, pc_o, inst_o,
    output imem_ack_i, imem_data_i, stall_i, flush_i, flush_pc_i
  );
endinterface
`default_nettype wire

// File: rtl/if_fetch.sv
`default_nettype none
// if_fetch: PC generation, single-outstanding imem request/ack, and an instruction
// queue that presents {pc, inst} to decode with valid/stall and flush redirect.
module if_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  if_fetch_if.master  bus
);

  localparam int          PTR_W      = $clog2(QUEUE_DEPTH);
  localparam logic [31:0] RESET_PC_A = RESET_PC & ~32'h3;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(QUEUE_DEPTH);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_FULL    = 2'd1,
    S_DISCARD = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      hold_q, hold_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;

  logic [31:0] qpc_q   [QUEUE_DEPTH];
  logic [31:0] qinst_q [QUEUE_DEPTH];

  logic req, ack, push, pop, valid;

  // Request is masked while rst is high so an abandoned transaction never completes.
  assign req   = (state_q != S_FULL) && !rst;
  assign ack   = req && bus.imem_ack_i;
  assign valid = (cnt_q != '0);
  assign push  = (state_q == S_FETCH) && ack && !bus.flush_i;
  assign pop   = valid && !bus.stall_i && !bus.flush_i;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    hold_d  = hold_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;

    if (bus.flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
      pc_d  = bus.flush_pc_i & ~32'h3;
      if (req && !ack) begin
        // An unacked request must stay on the bus; remember its address.
        state_d = S_DISCARD;
        if (state_q != S_DISCARD) begin
          hold_d = pc_q;
        end
      end else begin
        state_d = S_FETCH;
      end
    end else begin
      if (push) begin
        wr_d = wr_q + 1'b1;
        pc_d = pc_q + 32'd4;
      end
      if (pop) begin
        rd_d = rd_q + 1'b1;
      end
      cnt_d = cnt_q + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);

      case (state_q)
        S_DISCARD: begin
          if (ack) begin
            state_d = S_FETCH;
          end
        end
        default: begin
          state_d = (cnt_d < DEPTH_C) ? S_FETCH : S_FULL;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC_A;
      hold_q  <= RESET_PC_A;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      qpc_q[wr_q]   <= pc_q;
      qinst_q[wr_q] <= bus.imem_data_i;
    end
  end

  assign bus.imem_req_o  = req;
  assign bus.imem_addr_o = (state_q == S_DISCARD) ? hold_q : pc_q;
  assign bus.valid_o     = valid;
  assign bus.pc_o        = valid ? qpc_q[rd_q]   : 32'h0;
  assign bus.inst_o      = valid ? qinst_q[rd_q] : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// tb_if_fetch: directed vector table plus randomized traffic checked against a queue-level model.
module tb_if_fetch;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic clk;
  logic rst;
  logic ack_en;

  if_fetch_if bus ();

  if_fetch #(.RESET_PC(RPC), .QUEUE_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  // Memory answers combinationally when ack_en is set; data is junk otherwise.
  assign bus.imem_ack_i  = bus.imem_req_o && ack_en;
  assign bus.imem_data_i = bus.imem_ack_i ? memf(bus.imem_addr_o) : 32'hDEAD_BEEF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: fetch state kept as a queue of {pc, inst} plus a few flags.
  logic [63:0] m_q[$];
  logic [31:0] m_pc, m_hold, m_addr;
  bit          m_disc, m_req;

  task automatic model_step(input bit r, input bit s, input bit f,
                            input logic [31:0] fp, input bit a);
    bit acked;
    if (r) begin
      m_q.delete();
      m_pc   = RPC;
      m_disc = 1'b0;
      m_hold = RPC;
    end else begin
      acked = m_req && a;
      if (f) begin
        if (m_req && !acked) begin
          m_hold = m_addr;
          m_disc = 1'b1;
        end else begin
          m_disc = 1'b0;
        end
        m_q.delete();
        m_pc = fp & ~32'h3;
      end else if (m_disc) begin
        if (acked) m_disc = 1'b0;
      end else begin
        if (m_q.size() > 0 && !s) void'(m_q.pop_front());
        if (acked) begin
          m_q.push_back({m_pc, memf(m_pc)});
          m_pc = m_pc + 32'd4;
        end
      end
    end
    m_req  = m_disc || (m_q.size() < DEPTH);
    m_addr = m_disc ? m_hold : m_pc;
  endtask

  task automatic cycle(input bit r, input bit s, input bit f,
                       input logic [31:0] fp, input bit a);
    bit          pend;
    logic [31:0] paddr;
    logic [63:0] head;
    rst            = r;
    bus.stall_i    = s;
    bus.flush_i    = f;
    bus.flush_pc_i = fp;
    ack_en         = a;
    #1;
    pend  = bus.imem_req_o && !bus.imem_ack_i && !r;
    paddr = bus.imem_addr_o;
    model_step(r, s, f, fp, a);
    @(posedge clk);
    @(negedge clk);
    head = (m_q.size() > 0) ? m_q[0] : 64'h0;
    chk("req",   {31'h0, bus.imem_req_o}, {31'h0, m_req && !r});
    chk("addr",  bus.imem_addr_o, m_addr);
    chk("valid", {31'h0, bus.valid_o}, {31'h0, m_q.size() > 0});
    chk("pc",    bus.pc_o, head[63:32]);
    chk("inst",  bus.inst_o, head[31:0]);
    chk("align", {30'h0, bus.imem_addr_o[1:0]}, 32'h0);
    if (pend) begin
      chk("hold_req",  {31'h0, bus.imem_req_o}, 32'h1);
      chk("hold_addr", bus.imem_addr_o, paddr);
    end
  endtask

  typedef struct {
    bit          r, s, f;
    logic [31:0] fp;
    bit          a;
    bit          er;
    logic [31:0] ea;
    bit          ev;
    logic [31:0] ep;
  } vec_t;

  vec_t tv[23];

  initial begin
    //        r  s  f  flush_pc      ack  req addr          valid pc
    tv[0]  = '{1, 0, 0, 32'h0,         0,  0, 32'h0,         0, 32'h0};
    tv[1]  = '{0, 0, 0, 32'h0,         1,  1, 32'h4,         1, 32'h0};
    tv[2]  = '{0, 0, 0, 32'h0,         1,  1, 32'h8,         1, 32'h4};
    tv[3]  = '{0, 0, 0, 32'h0,         1,  1, 32'hC,         1, 32'h8};
    tv[4]  = '{0, 1, 0, 32'h0,         1,  1, 32'h10,        1, 32'h8};
    tv[5]  = '{0, 1, 0, 32'h0,         1,  1, 32'h14,        1, 32'h8};
    tv[6]  = '{0, 1, 0, 32'h0,         1,  0, 32'h18,        1, 32'h8};
    tv[7]  = '{0, 1, 0, 32'h0,         1,  0, 32'h18,        1, 32'h8};
    tv[8]  = '{0, 0, 0, 32'h0,         1,  1, 32'h18,        1, 32'hC};
    tv[9]  = '{0, 0, 0, 32'h0,         0,  1, 32'h18,        1, 32'h10};
    tv[10] = '{0, 0, 1, 32'h80,        0,  1, 32'h18,        0, 32'h0};
    tv[11] = '{0, 0, 1, 32'h100,       0,  1, 32'h18,        0, 32'h0};
    tv[12] = '{0, 0, 0, 32'h0,         1,  1, 32'h100,       0, 32'h0};
    tv[13] = '{0, 0, 0, 32'h0,         1,  1, 32'h104,       1, 32'h100};
    tv[14] = '{0, 0, 1, 32'h203,       1,  1, 32'h200,       0, 32'h0};
    tv[15] = '{0, 0, 0, 32'h0,         1,  1, 32'h204,       1, 32'h200};
    tv[16] = '{1, 0, 0, 32'h0,         0,  0, 32'h0,         0, 32'h0};
    tv[17] = '{0, 0, 0, 32'h0,         0,  1, 32'h0,         0, 32'h0};
    tv[18] = '{0, 0, 1, 32'hFFFF_FFF8, 0,  1, 32'h0,         0, 32'h0};
    tv[19] = '{0, 0, 0, 32'h0,         1,  1, 32'hFFFF_FFF8, 0, 32'h0};
    tv[20] = '{0, 0, 0, 32'h0,         1,  1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFF8};
    tv[21] = '{0, 0, 0, 32'h0,         1,  1, 32'h0,         1, 32'hFFFF_FFFC};
    tv[22] = '{0, 0, 0, 32'h0,         1,  1, 32'h4,         1, 32'h0};

    m_req  = 1'b0;
    m_disc = 1'b0;
    m_pc   = RPC;
    m_hold = RPC;
    m_addr = RPC;

    for (int i = 0; i < 23; i++) begin
      cycle(tv[i].r, tv[i].s, tv[i].f, tv[i].fp, tv[i].a);
      chk($sformatf("t%0d_req", i),   {31'h0, bus.imem_req_o}, {31'h0, tv[i].er});
      chk($sformatf("t%0d_addr", i),  bus.imem_addr_o, tv[i].ea);
      chk($sformatf("t%0d_valid", i), {31'h0, bus.valid_o}, {31'h0, tv[i].ev});
      chk($sformatf("t%0d_pc", i),    bus.pc_o, tv[i].ep);
      chk($sformatf("t%0d_inst", i),  bus.inst_o, tv[i].ev ? memf(tv[i].ep) : 32'h0);
    end

    // Slow memory: request held three cycles, flushed in the second wait cycle.
    cycle(1, 0, 0, 32'h0, 0);
    cycle(0, 0, 0, 32'h0, 0);
    cycle(0, 0, 1, 32'h100, 0);
    chk("slow_addr_held", bus.imem_addr_o, 32'h0);
    cycle(0, 0, 0, 32'h0, 1);
    chk("slow_next_addr", bus.imem_addr_o, 32'h100);
    chk("slow_no_valid", {31'h0, bus.valid_o}, 32'h0);
    cycle(0, 0, 0, 32'h0, 1);
    chk("slow_first_pc", bus.pc_o, 32'h100);

    // Randomized traffic with phases of heavy stall and slow memory.
    for (int i = 0; i < 3000; i++) begin
      int          sp, ap;
      bit          r, s, f, a;
      logic [31:0] fp;
      sp = ((i / 250) % 2 == 0) ? 25 : 85;
      ap = ((i / 400) % 2 == 0) ? 80 : 35;
      r  = ($urandom_range(0, 199) == 0);
      s  = ($urandom_range(0, 99) < sp);
      f  = ($urandom_range(0, 99) < 5);
      a  = ($urandom_range(0, 99) < ap);
      fp = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      cycle(r, s, f, fp, a);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage that sits directly upstream of the decode stage. It generates the fetch PC and runs a request/acknowledge handshake with instruction memory. Returned words go into a small instruction queue. The stage presents {pc, inst} pairs to decode with a valid/stall handshake, and a flush redirects fetch to a new PC.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset (word-aligned).
- `QUEUE_DEPTH`, 4, instruction queue entries (power of two, ≥2).

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; one clock, synchronous, active-high (`RstEnable` = 1'b1).
- `imem_req_o`  out  1  fetch request.
- `imem_addr_o`  out  32  fetch address; bits [1:0] always 0.
- `imem_ack_i`  in  1  memory accepts the request and returns data this cycle.
- `imem_data_i`  in  32  instruction word; valid when `imem_ack_i`=1.
- `stall_i`  in  1  decode cannot consume this cycle.
- `flush_i`  in  1  redirect fetch.
- `flush_pc_i`  in  32  redirect target; bits [1:0] ignored and forced to 0.
- `valid_o`  out  1  `pc_o`/`inst_o` hold a valid instruction.
- `pc_o`  out  32  PC of the instruction at the queue head.
- `inst_o`  out  32  instruction at the queue head.

## Operation
- State machine has three states:
  - FETCH: `imem_req_o`=1, `imem_addr_o`=pc.
  - FULL: `imem_req_o`=0.
  - DISCARD: `imem_req_o`=1, `imem_addr_o` holds the old outstanding address; the next ack's data is dropped.
- Memory handshake:
  - A transfer completes in a cycle with `imem_req_o`=1 and `imem_ack_i`=1.
  - Once asserted, `imem_req_o` and `imem_addr_o` stay stable until the ack. At most one request is outstanding.
  - `imem_data_i` is ignored when no ack.
- On ack in FETCH:
  - Write {pc, `imem_data_i`} to the queue tail.
  - pc <= pc + 4, mod 2^32; 32'hFFFF_FFFC wraps to 0.
- Request condition: occupancy after this edge < `QUEUE_DEPTH` → FETCH, else FULL. A held request never overflows the queue, because only a pop can change occupancy while a request is unacked.
- Pop: head is removed when `valid_o`=1 and `stall_i`=0. Push and pop in the same cycle leave occupancy unchanged.
- `valid_o` = queue not empty.
  - When `valid_o`=0: `pc_o`=0 and `inst_o`=0 (NOP to decode).
  - Outputs come from registered queue storage only; no combinational path from `imem_*` inputs.
- Flush (`flush_i`=1) has priority over push and pop in the same cycle:
  - Queue is emptied and pc <= `flush_pc_i`.
  - Request unacked this cycle (`imem_req_o`=1, `imem_ack_i`=0) → DISCARD.
  - Otherwise (including ack in the same cycle, whose data is dropped) → FETCH at `flush_pc_i`.
- DISCARD:
  - On ack, the data is dropped and the state moves to FETCH; the next cycle requests pc.
  - A second flush while in DISCARD updates pc only.

## Timing
- Reset values: `imem_req_o`=0, `imem_addr_o`=`RESET_PC`, `valid_o`=0, `pc_o`=0, `inst_o`=0; queue empty; pc=`RESET_PC`; no discard pending.
  - The first request is asserted in the first cycle after `rst` deasserts.
  - Reset mid-transaction abandons the outstanding request; instruction memory shares `rst`.
- Latency: ack in cycle N → entry visible on `valid_o`/`pc_o`/`inst_o` in cycle N+1.
- Throughput: with zero-wait memory (ack in the request cycle) and no stall, one instruction per cycle; `imem_addr_o` advances by 4 each cycle.
- Flush latency: flush at cycle N (no outstanding request) → `imem_addr_o`=`flush_pc_i` in N+1 → with zero-wait memory, `valid_o`=1 with that PC in N+2.
- Full queue under stall: `imem_req_o` drops in the cycle after the last slot is filled and reasserts the cycle after the first pop.

## Test plan
- Reset, `RESET_PC`=0, zero-wait memory, no stall → addresses 0,4,8,…; `valid_o` from cycle 2; `pc_o`=0,4,8 on consecutive cycles; `inst_o` matches memory.
- `stall_i` held high → exactly 4 entries fetched (PC 0..C); `imem_req_o` low; release → entries pop in order, then fetch resumes at 0x10.
- Memory with 3-cycle ack delay and `flush_i` (target 0x100) in the 2nd wait cycle → `imem_addr_o` held at old address until ack; data dropped; next request at 0x100; first valid `pc_o`=0x100.
- Flush in the same cycle as ack and pop → queue empty next cycle (`valid_o`=0, `inst_o`=0); next request 0x100.
- Fetch from 0xFFFF_FFF8 → PCs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- `rst` asserted for one cycle while a request is unacked → all outputs at reset values next cycle; fetch restarts at `RESET_PC`.
